// File: rtl/uart_tx_frame.sv
// UART transmitter: one word per valid/ready handshake, configurable width/parity/stop bits.
// Frames stream back-to-back with no idle gap when a new word is offered in the final stop cycle.
module uart_tx_frame #(
    parameter int CLOCKS_PER_BAUD = 868,
    parameter int DATA_WIDTH      = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  valid,
    output logic                  ready,
    output logic                  busy,
    output logic                  tx
);

    localparam int CW = $clog2(CLOCKS_PER_BAUD);
    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(CLOCKS_PER_BAUD - 1);
    localparam logic [IW-1:0] LAST_DATA  = IW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0] LAST_STOP  = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] sh;
    logic                  par_bit;
    logic                  accept;
    logic                  bit_done;

    // ready is only ever high in IDLE or the last stop-bit cycle, so accept
    // alone identifies both frame-start points.
    assign accept   = valid && ready;
    assign bit_done = (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            idx     <= '0;
            sh      <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            ready   <= 1'b1;
        end else if (accept) begin
            state   <= S_START;
            cnt     <= CNT_RELOAD;
            idx     <= '0;
            sh      <= data;
            par_bit <= (^data) ^ (PARITY == 1);
            tx      <= 1'b0;
            busy    <= 1'b1;
            ready   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: ;
                S_START: begin
                    if (bit_done) begin
                        state <= S_DATA;
                        cnt   <= CNT_RELOAD;
                        idx   <= '0;
                        tx    <= sh[0];
                        sh    <= sh >> 1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        cnt <= CNT_RELOAD;
                        if (idx == LAST_DATA) begin
                            idx <= '0;
                            if (PARITY != 0) begin
                                state <= S_PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            idx <= idx + IW'(1);
                            tx  <= sh[0];
                            sh  <= sh >> 1;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_PARITY: begin
                    if (bit_done) begin
                        state <= S_STOP;
                        cnt   <= CNT_RELOAD;
                        idx   <= '0;
                        tx    <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_STOP: begin
                    if (bit_done) begin
                        if (idx == LAST_STOP) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            tx    <= 1'b1;
                        end else begin
                            idx <= idx + IW'(1);
                            cnt <= CNT_RELOAD;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                        // Raise ready so it is visible exactly in the final stop cycle.
                        if (idx == LAST_STOP && cnt == CW'(1)) begin
                            ready <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three configurations (8N1/C4, 8O2/C4, 7E1/C3) checked cycle by
// cycle against a frame-level model built from start/data/parity/stop rules.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] data;
    logic       valid;
    int         sel;

    logic ready0, busy0, tx0;
    logic ready1, busy1, tx1;
    logic ready2, busy2, tx2;

    int errors = 0;
    int checks = 0;

    int cfg_c  [3] = '{4, 4, 3};
    int cfg_dw [3] = '{8, 8, 7};
    int cfg_p  [3] = '{0, 1, 2};
    int cfg_s  [3] = '{1, 2, 1};

    bit exp_bits[$];

    always #5 clk = ~clk;

    uart_tx_frame #(.CLOCKS_PER_BAUD(4), .DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .data(data[7:0]), .valid(valid && sel == 0),
        .ready(ready0), .busy(busy0), .tx(tx0));
    uart_tx_frame #(.CLOCKS_PER_BAUD(4), .DATA_WIDTH(8), .PARITY(1), .STOP_BITS(2)) u1 (
        .clk(clk), .rst_n(rst_n), .data(data[7:0]), .valid(valid && sel == 1),
        .ready(ready1), .busy(busy1), .tx(tx1));
    uart_tx_frame #(.CLOCKS_PER_BAUD(3), .DATA_WIDTH(7), .PARITY(2), .STOP_BITS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .data(data[6:0]), .valid(valid && sel == 2),
        .ready(ready2), .busy(busy2), .tx(tx2));

    function automatic logic o_tx(input int s);
        case (s)
            0: return tx0;
            1: return tx1;
            default: return tx2;
        endcase
    endfunction

    function automatic logic o_busy(input int s);
        case (s)
            0: return busy0;
            1: return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic o_ready(input int s);
        case (s)
            0: return ready0;
            1: return ready1;
            default: return ready2;
        endcase
    endfunction

    // Expected line levels for one frame, one entry per bit period.
    function automatic void build(input int s, input logic [8:0] w);
        int ones = 0;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < cfg_dw[s]; i++) begin
            exp_bits.push_back(w[i]);
            ones += int'(w[i]);
        end
        if (cfg_p[s] == 2) exp_bits.push_back(bit'(ones % 2));
        if (cfg_p[s] == 1) exp_bits.push_back(bit'(1 - ones % 2));
        for (int i = 0; i < cfg_s[s]; i++) exp_bits.push_back(1'b1);
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input int s, input int cycles, input string tag);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            chk($sformatf("%s_tx[%0d]", tag, k), o_tx(s), 1'b1);
            chk($sformatf("%s_busy[%0d]", tag, k), o_busy(s), 1'b0);
            chk($sformatf("%s_ready[%0d]", tag, k), o_ready(s), 1'b1);
        end
    endtask

    // Called at a negedge where ready is expected high; the word is accepted on the
    // following posedge. Returns at the negedge of the final stop cycle.
    task automatic run_frame(input int s, input logic [8:0] w, input bit hold,
                             input logic [8:0] next_w, input int pulse_k);
        int n;
        int c;
        build(s, w);
        n = exp_bits.size();
        c = cfg_c[s];
        data  = w;
        valid = 1'b1;
        chk($sformatf("s%0d_ready_pre", s), o_ready(s), 1'b1);
        for (int k = 1; k <= n * c; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (hold) begin
                    data = next_w;
                end else begin
                    valid = 1'b0;
                    data  = 9'($urandom);
                end
            end
            if (pulse_k != 0 && k == pulse_k) begin
                valid = 1'b1;
                data  = w ^ 9'h0FF;
            end else if (pulse_k != 0 && k == pulse_k + 1) begin
                valid = 1'b0;
            end
            chk($sformatf("s%0d_w%0h_tx[%0d]", s, w, k), o_tx(s), exp_bits[(k - 1) / c]);
            chk($sformatf("s%0d_w%0h_busy[%0d]", s, w, k), o_busy(s), 1'b1);
            chk($sformatf("s%0d_w%0h_ready[%0d]", s, w, k), o_ready(s), k == n * c);
        end
    endtask

    initial begin
        logic [8:0] w;
        logic [8:0] w2;
        int         s;
        bit         chain;

        // Reset with valid asserted: nothing may be accepted.
        sel   = 0;
        data  = 9'h0AA;
        valid = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_tx%0d", i), o_tx(i), 1'b1);
            chk($sformatf("rst_busy%0d", i), o_busy(i), 1'b0);
            chk($sformatf("rst_ready%0d", i), o_ready(i), 1'b1);
        end
        rst_n = 1'b1;
        valid = 1'b0;
        idle_chk(0, 2, "post_rst");

        // 8N1 C=4 0x55: alternating line, 40 busy cycles, ready pulse at the end.
        run_frame(0, 9'h055, 1'b0, 9'h0, 0);
        idle_chk(0, 3, "idle_55");

        // 8O2 C=4 0x03, then 7E1 C=3 0x7F.
        sel = 1;
        run_frame(1, 9'h003, 1'b0, 9'h0, 0);
        idle_chk(1, 3, "idle_03");
        sel = 2;
        run_frame(2, 9'h07F, 1'b0, 9'h0, 0);
        idle_chk(2, 3, "idle_7f");

        // Back-to-back with valid held high.
        sel = 0;
        run_frame(0, 9'h0A5, 1'b1, 9'h03C, 0);
        run_frame(0, 9'h03C, 1'b0, 9'h0, 0);
        idle_chk(0, 3, "idle_b2b");

        // Mid-frame valid pulse with another word must be dropped.
        run_frame(0, 9'h0C6, 1'b0, 9'h0, 15);
        idle_chk(0, 80, "idle_pulse");

        // Reset during data bit 3 abandons the frame.
        build(0, 9'h0C3);
        data  = 9'h0C3;
        valid = 1'b1;
        chk("midrst_ready_pre", o_ready(0), 1'b1);
        for (int k = 1; k <= 4 * 4 + 2; k++) begin
            @(negedge clk);
            if (k == 1) valid = 1'b0;
            chk($sformatf("midrst_tx[%0d]", k), o_tx(0), exp_bits[(k - 1) / 4]);
        end
        rst_n = 1'b0;
        valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        valid = 1'b0;
        chk("midrst_tx", o_tx(0), 1'b1);
        chk("midrst_busy", o_busy(0), 1'b0);
        chk("midrst_ready", o_ready(0), 1'b1);
        idle_chk(0, 3, "idle_midrst");
        run_frame(0, 9'h03A, 1'b0, 9'h0, 0);
        idle_chk(0, 3, "idle_after_rst");

        // Random words across all configurations, sometimes chained.
        for (int i = 0; i < 12; i++) begin
            s     = int'($urandom_range(0, 2));
            w     = 9'($urandom);
            w2    = 9'($urandom);
            chain = bit'($urandom_range(0, 1));
            sel   = s;
            run_frame(s, w, chain, w2, 0);
            if (chain) run_frame(s, w2, 1'b0, 9'h0, 0);
            idle_chk(s, 2, $sformatf("idle_rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter: serialises one word per valid/ready handshake onto a single `tx` line. Data width, parity mode, stop-bit count and baud divisor are configurable. Back-to-back words stream with no idle gap between frames. Sits between the host-facing response path (bridge/packetiser) and the board's UART TX pin, replacing the fixed 8N1 transmitter.

## Interface
- `CLOCKS_PER_BAUD`, 868: clock cycles per bit period. Legal range ≥ 2.
- `DATA_WIDTH`, 8: data bits per frame, 5..9. Sent LSB first.
- `PARITY`, 0: parity mode.
  - 0: none.
  - 1: odd; the parity bit makes the count of ones in data+parity odd.
  - 2: even.
- `STOP_BITS`, 1: stop-bit count, 1 or 2.

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `data` in DATA_WIDTH: word to send; sampled only in the accept cycle.
- `valid` in 1: upstream has a word.
- `ready` out 1: transmitter can accept a word this cycle.
- `busy` out 1: a frame is on the line.
- `tx` out 1: serial line, idle high.

## Operation
- Accept: a word is accepted on any rising edge where `valid && ready`. `data` is latched into an internal shift register.
- State machine: IDLE → START → DATA → PARITY → STOP → IDLE, or STOP → START on back-to-back.
  - PARITY is skipped when `PARITY==0`.
- Bit levels: START drives 0; DATA drives data bits LSB first; PARITY drives the computed bit; STOP drives 1.
- Bit length: every bit lasts exactly CLOCKS_PER_BAUD cycles.
- Baud counter: width `$clog2(CLOCKS_PER_BAUD)`. Reloads to CLOCKS_PER_BAUD−1 at each bit start and counts down to 0.
- Bit index: counts data bits 0..DATA_WIDTH−1 and stop bits 0..STOP_BITS−1.
- Frame length: (1 + DATA_WIDTH + (PARITY!=0) + STOP_BITS) × CLOCKS_PER_BAUD cycles.
- Parity: computed from the latched word at accept time (XOR reduction, inverted for odd), not from live `data`.
- `ready` is asserted:
  - in IDLE;
  - in the final cycle of the final stop bit (baud counter == 0, last stop bit).
  - It is deasserted in all other cycles.
- `valid` while `ready` is low is ignored; no word is queued.
- Back-to-back: an accept in the final stop-bit cycle moves directly to START on the next edge. `tx` goes 1 → 0 with zero idle cycles and `busy` stays high.
- Otherwise the last stop bit ends in IDLE: `busy` low, `ready` high, `tx` high.
- `rst_n` low at any time, including mid-frame, takes effect on the next edge:
  - state IDLE;
  - `tx`=1, `busy`=0, `ready`=1;
  - counters cleared, shift register contents irrelevant.
  - The partial frame is abandoned, not completed.
- `valid` during the reset cycle is not accepted.

## Timing
- Reset values: `tx`=1, `busy`=0, `ready`=1.
- All outputs are registered; none is combinational from inputs.
- Latency: accept on edge t → `tx`=0 and `busy`=1 from edge t+1.
- Bit k of the frame (START = bit 0) occupies edges t+1+k·C through t+(k+1)·C, where C = CLOCKS_PER_BAUD.
- `ready` rises for exactly one cycle at edge t+N·C, where N is the frame bit count.
  - If not accepted there: `busy` falls and `ready` stays high from edge t+N·C+1.
- Back-to-back frames repeat with period exactly N·C cycles.
- Throughput: one word per N·C cycles maximum.
- `ready` is never high while `busy` is high, except in the final stop-bit cycle.

## Test plan
- 8N1, C=4, reset then accept 0x55 at edge t:
  - `tx` sequence per 4-cycle bit is 0,1,0,1,0,1,0,1,0,1.
  - `busy` high for 40 cycles; `ready` pulses at t+40; line idle from t+41.
- 8O2, C=4, send 0x03 (two ones):
  - frame is start 0, bits 1,1,0,0,0,0,0,0, parity 1, stop 1,1 — 12 bits, 48 cycles.
- 7E1, C=3, send 0x7F:
  - parity bit 1 (seven ones → even needs 1); frame 10 bits, 30 cycles.
- Back-to-back 8N1, C=4, `valid` held high with 0xA5 then 0x3C:
  - second start bit begins at t+41 with no idle gap;
  - exactly two frames; `busy` continuous for 80 cycles.
- `valid` pulsed mid-frame (ready low) with a different word:
  - ignored; only the original word is transmitted and no extra frame follows.
- `rst_n` low for one cycle during data bit 3:
  - next edge `tx`=1, `busy`=0, `ready`=1;
  - a subsequent accept produces a complete, correct frame.
